// File: rtl/memory_access_if.sv
// memory_access_if: EX/MEM input bundle and MEM/WB output bundle of the MEM stage,
// plus the debug read port. The o_misaligned member exists only when the
// MEM_ALIGN_CHECK_EN macro is defined.
interface memory_access_if #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8
);
  logic               i_stall;
  logic               i_halt;
  logic [NB_DATA-1:0] i_result;
  logic [NB_DATA-1:0] i_data_wr;
  logic [4:0]         i_write_reg;
  logic               i_mem2reg;
  logic               i_memRead;
  logic               i_memWrite;
  logic               i_regWrite;
  logic [1:0]         i_size;
  logic               i_unsigned;
  logic [NB_ADDR-1:0] i_dbg_addr;
  logic [NB_DATA-1:0] o_dbg_data;
  logic [NB_DATA-1:0] o_read_data;
  logic [NB_DATA-1:0] o_result;
  logic [4:0]         o_write_reg;
  logic               o_mem2reg;
  logic               o_regWrite;
`ifdef MEM_ALIGN_CHECK_EN
  logic               o_misaligned;

  modport master (
    output i_stall, i_halt, i_result, i_data_wr, i_write_reg, i_mem2reg,
           i_memRead, i_memWrite, i_regWrite, i_size, i_unsigned, i_dbg_addr,
    input  o_dbg_data, o_read_data, o_result, o_write_reg, o_mem2reg, o_regWrite,
           o_misaligned
  );

  modport slave (
    input  i_stall, i_halt, i_result, i_data_wr, i_write_reg, i_mem2reg,
           i_memRead, i_memWrite, i_regWrite, i_size, i_unsigned, i_dbg_addr,
    output o_dbg_data, o_read_data, o_result, o_write_reg, o_mem2reg, o_regWrite,
           o_misaligned
  );
`else
  modport master (
    output i_stall, i_halt, i_result, i_data_wr, i_write_reg, i_mem2reg,
           i_memRead, i_memWrite, i_regWrite, i_size, i_unsigned, i_dbg_addr,
    input  o_dbg_data, o_read_data, o_result, o_write_reg, o_mem2reg, o_regWrite
  );

  modport slave (
    input  i_stall, i_halt, i_result, i_data_wr, i_write_reg, i_mem2reg,
           i_memRead, i_memWrite, i_regWrite, i_size, i_unsigned, i_dbg_addr,
    output o_dbg_data, o_read_data, o_result, o_write_reg, o_mem2reg, o_regWrite
  );
`endif
endinterface

// File: rtl/memory_access.sv
// memory_access: MEM stage of the 5-stage MIPS pipeline. Byte/half/word loads and
// stores against an internal little-endian word memory, registered MEM/WB bundle,
// and a combinational debug read port.
// Optional feature: define MEM_ALIGN_CHECK_EN to flag misaligned half/word accesses,
// suppress their stores, zero their load data and kill their register write.
module memory_access #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8
) (
  input  logic           clk,
  input  logic           i_rst_n,
  memory_access_if.slave bus
);
  localparam int DEPTH = 2 ** NB_ADDR;

  logic [NB_DATA-1:0] r_mem [DEPTH];

  logic [NB_ADDR-1:0] w_idx;
  logic [1:0]         w_lane;
  logic               w_blocked;
  logic               w_store;
  logic               w_misaligned;
  logic [3:0]         w_be;
  logic [NB_DATA-1:0] w_wr_data;
  logic [NB_DATA-1:0] w_word;
  logic [NB_DATA-1:0] w_load;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic               w_unused_addr;

  assign w_idx         = bus.i_result[NB_ADDR+1:2];
  assign w_lane        = bus.i_result[1:0];
  assign w_blocked     = bus.i_stall | bus.i_halt;
  assign w_word        = r_mem[w_idx];
  assign bus.o_dbg_data = r_mem[bus.i_dbg_addr];
  assign w_unused_addr = ^bus.i_result[NB_DATA-1:NB_ADDR+2];

`ifdef MEM_ALIGN_CHECK_EN
  // Half accesses need an even byte address, word accesses a multiple of four.
  always_comb begin
    w_misaligned = 1'b0;
    if (bus.i_memRead || bus.i_memWrite) begin
      if (bus.i_size == 2'b01)
        w_misaligned = w_lane[0];
      else if (bus.i_size[1])
        w_misaligned = (w_lane != 2'b00);
    end
  end
`else
  assign w_misaligned = 1'b0;
`endif

  assign w_store = bus.i_memWrite & ~w_blocked & ~w_misaligned;

  // Build byte enables and lane-replicated write data for the access size.
  always_comb begin
    w_be      = 4'b0000;
    w_wr_data = '0;
    case (bus.i_size)
      2'b00: begin
        w_be      = 4'b0001 << w_lane;
        w_wr_data = {4{bus.i_data_wr[7:0]}};
      end
      2'b01: begin
        w_be      = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wr_data = {2{bus.i_data_wr[15:0]}};
      end
      default: begin
        w_be      = 4'b1111;
        w_wr_data = bus.i_data_wr;
      end
    endcase
  end

  // Byte-lane write into the data memory; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_store) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b])
          r_mem[w_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
      end
    end
  end

  // Extract the addressed byte/half from the pre-store word and extend it.
  always_comb begin
    w_byte = w_word[8*w_lane +: 8];
    w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];
    case (bus.i_size)
      2'b00:   w_load = bus.i_unsigned ? {{(NB_DATA-8){1'b0}}, w_byte}
                                       : {{(NB_DATA-8){w_byte[7]}}, w_byte};
      2'b01:   w_load = bus.i_unsigned ? {{(NB_DATA-16){1'b0}}, w_half}
                                       : {{(NB_DATA-16){w_half[15]}}, w_half};
      default: w_load = w_word;
    endcase
  end

  // MEM/WB pipeline register: holds while stalled or halted, clears on reset.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_read_data  <= '0;
      bus.o_result     <= '0;
      bus.o_write_reg  <= '0;
      bus.o_mem2reg    <= 1'b0;
      bus.o_regWrite   <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      bus.o_misaligned <= 1'b0;
`endif
    end else if (!w_blocked) begin
      bus.o_read_data  <= (bus.i_memRead && !w_misaligned) ? w_load : '0;
      bus.o_result     <= bus.i_result;
      bus.o_write_reg  <= bus.i_write_reg;
      bus.o_mem2reg    <= bus.i_mem2reg;
      bus.o_regWrite   <= bus.i_regWrite & ~w_misaligned;
`ifdef MEM_ALIGN_CHECK_EN
      bus.o_misaligned <= w_misaligned;
`endif
    end
  end
endmodule

// File: doc/memory_access.md
# memory_access

MEM stage of the 5-stage MIPS pipeline, directly downstream of `instruction_execute`. It consumes the EX/MEM bundle: ALU result as address, store data, destination register and control bits. It performs byte, halfword and word loads and stores against an internal little-endian data memory. It registers the MEM/WB bundle for write-back, and provides a debug read port for inspecting memory.

## Interface
Parameters:
- `NB_DATA`, 32: datapath width; must be 32.
- `NB_ADDR`, 8: word-address bits; memory is 2**NB_ADDR words.

Ports:
- `clk`  in  1: clock, rising edge.
- `i_rst_n`  in  1: reset, asynchronous, active-low.
- `i_stall`  in  1: hold MEM/WB register; block stores.
- `i_halt`  in  1: same effect as `i_stall`, for the duration it is asserted.
- `i_result`  in  NB_DATA: ALU result, which is the byte address for memory ops.
- `i_data_wr`  in  NB_DATA: store data (rt value).
- `i_write_reg`  in  5: destination register from EX.
- `i_mem2reg`, `i_memRead`, `i_memWrite`, `i_regWrite`  in  1 each: control bits from EX.
- `i_size`  in  2: access size; 00 = byte, 01 = half, 11 = word, 10 treated as word.
- `i_unsigned`  in  1: zero-extend loads (lbu/lhu) when 1, sign-extend when 0.
- `i_dbg_addr`  in  NB_ADDR: debug word address.
- `o_dbg_data`  out  NB_DATA: combinational word at `i_dbg_addr`.
- `o_read_data`  out  NB_DATA: registered, extended load data.
- `o_result`  out  NB_DATA: registered copy of `i_result`.
- `o_write_reg`  out  5: registered destination register.
- `o_mem2reg`, `o_regWrite`  out  1 each: registered control bits.
- `o_misaligned`  out  1: registered misalignment flag; present only with `MEM_ALIGN_CHECK_EN`.

## Operation
Addressing:
- Word index = `i_result[NB_ADDR+1:2]`; byte lane = `i_result[1:0]`, with lane 0 = bits 7:0.
- Upper address bits are ignored, so addresses wrap modulo 4·2**NB_ADDR bytes.

Stores:
- Occur on the rising edge when `i_memWrite` && !`i_stall` && !`i_halt`.
- Byte: writes lane `i_result[1:0]` from `i_data_wr[7:0]`.
- Half: writes lanes {2h+1, 2h} from `i_data_wr[15:0]`, where h = `i_result[1]`.
- Word: writes all four lanes.
- Lanes not selected are unchanged.

Loads:
- Read the addressed word combinationally.
- Extract the selected byte or half and extend it per `i_unsigned` to NB_DATA.
- When `i_memRead` = 0, the load data latched into `o_read_data` is 0.

MEM/WB register:
- Updated every clock unless stalled or halted.
- While stalled or halted, all outputs hold their values.

Other rules:
- Memory contents are not reset. A load from a word never written returns X.
- `o_dbg_data` ignores stall and halt.
- `i_memRead` and `i_memWrite` both set: the store occurs, and the load returns the pre-store word.

## Timing
- Reset (async, takes effect immediately): `o_read_data`, `o_result`, `o_write_reg`, `o_mem2reg`, `o_regWrite`, `o_misaligned` are all 0.
- Load latency: 1 cycle. Data appears on `o_read_data` after the edge that captures the load.
- Store→load to the same address in the next cycle returns the new data; no bypass is needed.
- Reset asserted mid-store: the write is not guaranteed. Outputs clear asynchronously.
- Stall released: the instruction presented at the next edge is processed normally.

## Configuration
`MEM_ALIGN_CHECK_EN` defined:
- A half access with `i_result[0]`=1, or a word access with `i_result[1:0]`≠0, is misaligned.
- A misaligned store is suppressed.
- A misaligned load latches `o_read_data` = 0.
- `o_regWrite` is registered as 0 and `o_misaligned` is registered as 1.
- `o_misaligned` is registered as 0 for aligned accesses and for instructions with neither `i_memRead` nor `i_memWrite` set.

`MEM_ALIGN_CHECK_EN` undefined:
- The `o_misaligned` port is absent.
- Half accesses ignore `i_result[0]`; word accesses ignore `i_result[1:0]`.

## Test plan
- Word round trip: sw 0x12345678 to byte address 0x10, then lw 0x10 → `o_read_data` = 0x12345678 one cycle after the lw edge.
- Byte extraction: after the word store above, lb 0x11 → 0x00000056. Then sb 0x80 to 0x10; lb 0x10 → 0xFFFFFF80; lbu 0x10 → 0x00000080.
- Halfword: sh 0xBEEF to 0x12 on top of the word 0x12345678 → lw 0x10 = 0xBEEF5678; lh 0x12 → 0xFFFFBEEF; lhu 0x12 → 0x0000BEEF.
- Stall/halt: sw 0xDEADBEEF to 0x20 with `i_stall`=1 for 3 cycles → `o_dbg_data`@word 8 unchanged and outputs held. Release stall → write lands; `o_result` = 0x20.
- Misaligned (macro on): lw 0x13 with `i_regWrite`=1 → `o_misaligned`=1, `o_regWrite`=0, `o_read_data`=0. sw 0x13 → memory unchanged.
- Reset mid-stream: assert `i_rst_n`=0 between edges → all outputs 0 immediately. Previously stored word 0x10 is still readable on `o_dbg_data`.
